// File: rtl/muldiv_iter_if.sv
// Handshake and result bus between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; the muldiv_iter unit owns the slave side.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             result_ok;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, result_ok, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, result_ok, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide unit with its own HI/LO pair (IDLE -> CALC -> FIX).
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip CALC and go straight to FIX.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  io_md
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_opd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_raw_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_result_ok;
  logic               r_div_by_zero;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shl;
  logic               w_div_borrow;
  logic [WIDTH-1:0]   w_div_rem_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_remd;

  // Operand magnitudes for the signed ops; unsigned ops pass through raw.
  assign w_sgn   = (io_md.op == OP_MULT) || (io_md.op == OP_DIV);
  assign w_abs_a = f_cneg_w(io_md.src_a, w_sgn & io_md.src_a[WIDTH-1]);
  assign w_abs_b = f_cneg_w(io_md.src_b, w_sgn & io_md.src_b[WIDTH-1]);

  // Multiply: upper half accumulates the multiplicand, multiplier shifts out of the low end.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});

  // Divide: restoring step, dividend bits shift out of r_acc while quotient bits shift in.
  assign w_div_shl    = {r_rem, r_acc[WIDTH-1]};
  assign w_div_borrow = (w_div_shl < {1'b0, r_opd});
  assign w_div_rem_nx = w_div_borrow ? w_div_shl[WIDTH-1:0] : WIDTH'(w_div_shl - {1'b0, r_opd});

  assign w_prod = f_cneg_2w(r_acc, r_neg_q);
  assign w_quot = f_cneg_w(r_acc[WIDTH-1:0], r_neg_q);
  assign w_remd = f_cneg_w(r_rem, r_neg_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_result_ok   <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_result_ok   <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_md.start && !io_md.cancel) begin
            case (io_md.op)
              OP_MULT, OP_MULTU: begin
                r_is_div <= 1'b0;
                r_neg_q  <= w_sgn & (io_md.src_a[WIDTH-1] ^ io_md.src_b[WIDTH-1]);
                r_neg_r  <= 1'b0;
                r_dbz    <= 1'b0;
                r_opd    <= w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
                r_rem    <= '0;
                r_cnt    <= '0;
                r_state  <= ST_CALC;
                r_busy   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                if ((w_abs_a == '0) || (w_abs_b == '0)) begin
                  r_acc   <= '0;
                  r_state <= ST_FIX;
                end
`endif
              end
              OP_DIV, OP_DIVU: begin
                r_is_div <= 1'b1;
                r_neg_q  <= w_sgn & (io_md.src_a[WIDTH-1] ^ io_md.src_b[WIDTH-1]);
                r_neg_r  <= w_sgn & io_md.src_a[WIDTH-1];
                r_dbz    <= (io_md.src_b == '0);
                r_opd    <= w_abs_b;
                r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                r_rem    <= '0;
                r_raw_a  <= io_md.src_a;
                r_cnt    <= '0;
                r_state  <= ST_CALC;
                r_busy   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                if (io_md.src_b == '0) begin
                  r_state <= ST_FIX;
                end else if (w_abs_a < w_abs_b) begin
                  r_acc   <= '0;
                  r_rem   <= w_abs_a;
                  r_state <= ST_FIX;
                end
`endif
              end
              OP_MTHI: r_hi <= io_md.src_a;
              OP_MTLO: r_lo <= io_md.src_a;
              default: ;
            endcase
          end
        end

        ST_CALC: begin
          if (io_md.cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              r_rem             <= w_div_rem_nx;
              r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], ~w_div_borrow};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= ST_FIX;
            end
          end
        end

        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          // Sign correction and HI/LO write happen together on the exit edge.
          if (!io_md.cancel) begin
            if (r_dbz) begin
              r_hi <= r_raw_a;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_hi <= w_remd;
              r_lo <= w_quot;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
            r_result_ok   <= 1'b1;
            r_div_by_zero <= r_dbz;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_md.busy        = r_busy;
  assign io_md.result_ok   = r_result_ok;
  assign io_md.div_by_zero = r_div_by_zero;
  assign io_md.hi          = r_hi;
  assign io_md.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized and directed bench for muldiv_iter against a plain-arithmetic model of HI/LO.
// Build with MULDIV_EARLY_OUT_EN defined to expect the shortened trivial-case latency.
module tb_muldiv_iter;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io_md(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi, m_lo;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference results from ordinary 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = m_hi;
    lo  = m_lo;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          dbz = 1'b1; lo = '1; hi = a;
        end else if (op == 3'd2) begin
          lo = 32'(sa / sb); hi = 32'(sa % sb);
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ma, mb;
    bit trivial;
    ma = (op == 3'd0 || op == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
    mb = (op == 3'd0 || op == 3'd2) ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (op <= 3'd1) trivial = (ma == 0) || (mb == 0);
    else            trivial = (mb == 0) || (ma < mb);
    return (EARLY && trivial) ? 2 : W + 2;
  endfunction

  // Full mul/div transaction; returns in the result_ok cycle so the next op can start back-to-back.
  task automatic do_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic ed;
    int lat, n, drops;
    model(op, a, b, eh, el, ed);
    lat = exp_latency(op, a, b);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    n = 1; drops = 0;
    check_val("busy_c1", {63'b0, bus.busy}, 64'd1);
    check_val("rok_c1", {63'b0, bus.result_ok}, 64'd0);
    while (!bus.result_ok && n < W + 10) begin
      if (!bus.busy) drops++;
      tick;
      n++;
    end
    check_val("latency", 64'(n), 64'(lat));
    check_val("busy_hold", 64'(drops), 64'd0);
    check_val("rok", {63'b0, bus.result_ok}, 64'd1);
    check_val("busy_at_rok", {63'b0, bus.busy}, 64'd0);
    check_val("hi", {32'b0, bus.hi}, {32'b0, eh});
    check_val("lo", {32'b0, bus.lo}, {32'b0, el});
    check_val("dbz", {63'b0, bus.div_by_zero}, {63'b0, ed});
    m_hi = eh;
    m_lo = el;
  endtask

  // MTHI/MTLO or reserved op: single-cycle, never busy, never result_ok.
  task automatic do_idle_op(input logic [2:0] op, input logic [W-1:0] a);
    bus.op = op; bus.src_a = a; bus.src_b = $urandom; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    check_val("mt_hi", {32'b0, bus.hi}, {32'b0, m_hi});
    check_val("mt_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    check_val("mt_busy", {63'b0, bus.busy}, 64'd0);
    check_val("mt_rok", {63'b0, bus.result_ok}, 64'd0);
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic watch_quiet(input string tag, input int cycles);
    int roks, busies;
    roks = 0; busies = 0;
    repeat (cycles) begin
      tick;
      if (bus.result_ok) roks++;
      if (bus.busy) busies++;
    end
    check_val({tag, "_no_rok"}, 64'(roks), 64'd0);
    check_val({tag, "_no_busy"}, 64'(busies), 64'd0);
    check_val({tag, "_hi"}, {32'b0, bus.hi}, {32'b0, m_hi});
    check_val({tag, "_lo"}, {32'b0, bus.lo}, {32'b0, m_lo});
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) tick;
    check_val("rst_busy", {63'b0, bus.busy}, 64'd0);
    check_val("rst_rok", {63'b0, bus.result_ok}, 64'd0);
    check_val("rst_dbz", {63'b0, bus.div_by_zero}, 64'd0);
    check_val("rst_hi", {32'b0, bus.hi}, 64'd0);
    check_val("rst_lo", {32'b0, bus.lo}, 64'd0);
    rst = 1'b1;
    tick;

    // Directed cases, issued back-to-back.
    do_calc(3'd0, 32'hFFFF_FFFE, 32'd3);
    check_val("t1_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);
    check_val("t1_lo", {32'b0, bus.lo}, 64'hFFFF_FFFA);
    do_calc(3'd1, 32'hFFFF_FFFE, 32'd3);
    check_val("t2_hi", {32'b0, bus.hi}, 64'h0000_0002);
    do_calc(3'd2, 32'hFFFF_FFF9, 32'd2);
    check_val("t3_lo", {32'b0, bus.lo}, 64'hFFFF_FFFD);
    check_val("t3_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);
    do_calc(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("t3b_lo", {32'b0, bus.lo}, 64'h8000_0000);
    check_val("t3b_hi", {32'b0, bus.hi}, 64'h0);
    do_calc(3'd3, 32'd100, 32'd0);
    check_val("t4_lo", {32'b0, bus.lo}, 64'hFFFF_FFFF);
    check_val("t4_hi", {32'b0, bus.hi}, 64'h64);
    do_calc(3'd2, 32'hFFFF_FFF9, 32'd0);
    do_calc(3'd0, 32'd0, 32'h1234_5678);
    do_calc(3'd2, 32'hFFFF_FFFD, 32'd7);
    tick;
    check_val("rok_pulse", {63'b0, bus.result_ok}, 64'd0);

    // Cancel mid-CALC, with a start attempted while busy.
    do_idle_op(3'd4, 32'h1234_5678);
    bus.op = 3'd0; bus.src_a = 32'd5; bus.src_b = 32'd7; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    bus.op = 3'd4; bus.src_a = 32'hDEAD_BEEF; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check_val("t5_busy_c6", {63'b0, bus.busy}, 64'd1);
    repeat (4) tick;
    bus.cancel = 1'b1;
    tick;
    bus.cancel = 1'b0;
    check_val("t5_busy_c11", {63'b0, bus.busy}, 64'd0);
    check_val("t5_hi", {32'b0, bus.hi}, 64'h1234_5678);
    watch_quiet("t5", W + 5);

    // Cancel during FIX.
    bus.op = 3'd3; bus.src_a = 32'd77; bus.src_b = 32'd5; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (W) tick;
    bus.cancel = 1'b1;
    tick;
    bus.cancel = 1'b0;
    check_val("fixcan_rok", {63'b0, bus.result_ok}, 64'd0);
    watch_quiet("fixcan", 5);

    // Reset in the middle of a DIV.
    bus.op = 3'd2; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (19) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    check_val("t6_hi", {32'b0, bus.hi}, 64'd0);
    check_val("t6_lo", {32'b0, bus.lo}, 64'd0);
    check_val("t6_busy", {63'b0, bus.busy}, 64'd0);
    check_val("t6_rok", {63'b0, bus.result_ok}, 64'd0);
    watch_quiet("t6", W + 5);
    do_idle_op(3'd5, 32'hA5A5_A5A5);
    check_val("t6_mtlo", {32'b0, bus.lo}, 64'hA5A5_A5A5);

    // Start with cancel held is ignored.
    bus.cancel = 1'b1;
    do_idle_op(3'd6, 32'h0);
    bus.op = 3'd4; bus.src_a = 32'hCAFE_F00D; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    check_val("cancel_start_hi", {32'b0, bus.hi}, {32'b0, m_hi});

    // Random mix, including reserved ops and register moves.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op <= 3'd3) do_calc(op, rand_val(), rand_val());
      else            do_idle_op(op, rand_val());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
